instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, the fetch address after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on the posedge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port stall_IF  input  1  high: downstream IF/ID register is holding; the current fetch output is not consumed.
REQ-005 SHALL provide port redirect  input  1  high: taken branch or jump; fetch restarts at PCTarget.
REQ-006 SHALL provide port PCTarget  input  32  redirect address.
REQ-007 SHALL provide port imem_req  output  1  instruction memory read request.
REQ-008 SHALL provide port imem_addr  output  32  instruction memory read address.
REQ-009 SHALL provide port imem_ack  input  1  imem_rdata valid for the current request; ack latency is variable, 0..N cycles.
REQ-010 SHALL provide port imem_rdata  input  32  instruction word.
REQ-011 SHALL provide port instr_IF  output  32  fetched instruction to the IF/ID register.
REQ-012 SHALL provide port PC_IF  output  32  address of instr_IF.
REQ-013 SHALL provide port PCPlus4_IF  output  32  PC_IF+4.
REQ-014 SHALL provide port valid_IF  output  1  instr_IF/PC_IF carry a real instruction this cycle.
REQ-015 SHALL provide port bubble_FD  output  1  equal to ~valid_IF; drives the IF/ID clear.

Function
REQ-016 SHALL hold a 32-bit PC register, a 32-bit instruction buffer (ibuf), a 32-bit buffered PC (ibuf_pc) and a state register with states RST_S, FETCH and HOLD.
REQ-017 SHALL force PCTarget[1:0] to 2'b00 wherever it is loaded; PC+4 wraps modulo 2^32 (32'hFFFFFFFC+4 = 0).
REQ-018 RST_S: imem_req=0 and valid_IF=0; imem_ack is ignored; next state is always FETCH.
REQ-019 FETCH: imem_req=1 and imem_addr=PC, held stable until imem_ack or redirect.
REQ-020 FETCH, ack, no stall, no redirect: valid_IF=1, instr_IF=imem_rdata, PC_IF=PC (same cycle); PC<=PC+4; state stays FETCH, giving 1 instruction per cycle with zero-latency memory.
REQ-021 FETCH, ack, stall, no redirect: ibuf<=imem_rdata, ibuf_pc<=PC, PC<=PC+4, state<=HOLD; valid_IF=1 with rdata outputs this cycle.
REQ-022 FETCH, no ack: valid_IF=0, instr_IF=0, PC_IF=PC; stall has no effect on state.
REQ-023 HOLD: imem_req=0; outputs instr_IF=ibuf, PC_IF=ibuf_pc, valid_IF=1; on stall_IF=0 the buffered word is consumed and state<=FETCH; on stall_IF=1 state stays HOLD.
REQ-024 Redirect has priority over ack and stall in every state except RST_S: valid_IF=0 this cycle, PC<=PCTarget, ibuf is discarded, state<=FETCH; any ack in that cycle is dropped.
REQ-025 SHALL drive PCPlus4_IF = PC_IF+4 in all states.
REQ-026 Memory contract: at most one outstanding request; imem_ack in a cycle with imem_req=0 is ignored.
REQ-027 A request abandoned by redirect: the memory returns the new address's data; imem_addr changes in the cycle after redirect.

Reset
REQ-028 With rst=1 at a posedge: PC<=RESET_PC, ibuf<=0, ibuf_pc<=0, state<=RST_S; overrides redirect, stall and ack.
REQ-029 While in RST_S: outputs imem_req=0, valid_IF=0, bubble_FD=1, instr_IF=0, PC_IF=RESET_PC, PCPlus4_IF=RESET_PC+4.
REQ-030 Reset asserted mid-transaction SHALL abandon the request without consuming the pending ack.

Verification
REQ-031 Reset, then ack tied 1 with rdata=addr^32'hA5A5A5A5: cycle 1 shows imem_req=0; cycles 2.. show PC_IF 0,4,8,C with valid_IF=1 every cycle.
REQ-032 Ack held 2 cycles after request at PC=8: valid_IF=0 and bubble_FD=1 for 2 cycles, then PC_IF=8 with valid_IF=1; imem_addr=8 throughout the wait.
REQ-033 Stall asserted in the cycle of the ack at PC=10 and held 3 cycles: state HOLD, instr_IF/PC_IF=10 stable, imem_req=0; after stall drops, the next fetch uses addr 14.
REQ-034 Redirect to 32'h00000203 while in HOLD with stall=1: valid_IF=0 that cycle; next imem_addr=32'h00000200; the buffered word is never re-presented.
REQ-035 Redirect and ack in the same FETCH cycle: rdata is dropped and valid_IF=0; with PC at 32'hFFFFFFFC and ack, next PC=0.
REQ-036 rst=1 while waiting for ack with redirect=1: state RST_S, PC=RESET_PC; an ack in the RST_S cycle does not produce valid_IF.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read channel: single outstanding request, variable-latency ack.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time, buffers the word
// while the IF/ID register stalls, and restarts on redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_IF,
    input  logic                       redirect,
    input  logic [31:0]                PCTarget,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instr_IF,
    output logic [31:0]                PC_IF,
    output logic [31:0]                PCPlus4_IF,
    output logic                       valid_IF,
    output logic                       bubble_FD
);

    localparam logic [1:0] RST_S = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] ibuf_pc_q, ibuf_pc_d;
    logic [31:0] target_aligned;

    assign target_aligned = {PCTarget[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ibuf_d        = ibuf_q;
        ibuf_pc_d     = ibuf_pc_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        instr_IF      = 32'h0;
        PC_IF         = pc_q;
        valid_IF      = 1'b0;

        case (state_q)
            RST_S: begin
                // Redirect and ack are both ignored on the way out of reset.
                state_d = FETCH;
            end
            FETCH: begin
                imem.imem_req = 1'b1;
                if (redirect) begin
                    pc_d    = target_aligned;
                    state_d = FETCH;
                end else if (imem.imem_ack) begin
                    valid_IF = 1'b1;
                    instr_IF = imem.imem_rdata;
                    pc_d     = pc_q + 32'd4;
                    if (stall_IF) begin
                        ibuf_d    = imem.imem_rdata;
                        ibuf_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target_aligned;
                    state_d = FETCH;
                end else begin
                    valid_IF = 1'b1;
                    instr_IF = ibuf_q;
                    PC_IF    = ibuf_pc_q;
                    if (!stall_IF) begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = RST_S;
            end
        endcase
    end

    assign PCPlus4_IF = PC_IF + 32'd4;
    assign bubble_FD  = ~valid_IF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_S;
            pc_q      <= RESET_PC;
            ibuf_q    <= 32'h0;
            ibuf_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ibuf_q    <= ibuf_d;
            ibuf_pc_q <= ibuf_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes expected fetches into a
// scoreboard queue, a negedge monitor pops and compares every valid output.
module tb_instr_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_IF;
    logic        redirect;
    logic [31:0] PCTarget;
    logic        ack;
    logic [31:0] instr_IF;
    logic [31:0] PC_IF;
    logic [31:0] PCPlus4_IF;
    logic        valid_IF;
    logic        bubble_FD;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    instr_fetch_unit_if u_if ();

    // Memory returns a word derived from its address; ack is driven directly.
    assign u_if.imem_ack   = ack;
    assign u_if.imem_rdata = u_if.imem_addr ^ MAGIC;

    instr_fetch_unit #(
        .RESET_PC (32'h00000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_IF   (stall_IF),
        .redirect   (redirect),
        .PCTarget   (PCTarget),
        .imem       (u_if.master),
        .instr_IF   (instr_IF),
        .PC_IF      (PC_IF),
        .PCPlus4_IF (PCPlus4_IF),
        .valid_IF   (valid_IF),
        .bubble_FD  (bubble_FD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, pc ^ MAGIC});
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [31:0] tgt,
                       input logic st, input logic ak);
        @(posedge clk);
        #1;
        rst      = r;
        redirect = rd;
        PCTarget = tgt;
        stall_IF = st;
        ack      = ak;
        #2;
    endtask

    // Monitor: every valid output must match the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        chk("bubble_inv", {31'b0, bubble_FD}, {31'b0, ~valid_IF});
        if (valid_IF === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got PC_IF %h expected no output at %0t",
                         PC_IF, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", PC_IF, e[63:32]);
                chk("sb_instr", instr_IF, e[31:0]);
                chk("sb_pc4", PCPlus4_IF, e[63:32] + 32'd4);
            end
        end
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; PCTarget = 32'h0; stall_IF = 1'b0; ack = 1'b0;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_req", {31'b0, u_if.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid_IF}, 32'd0);
        chk("rst_bubble", {31'b0, bubble_FD}, 32'd1);
        chk("rst_instr", instr_IF, 32'h0);
        chk("rst_pc", PC_IF, 32'h0);
        chk("rst_pc4", PCPlus4_IF, 32'h4);

        // Zero-latency memory: first cycle out of reset issues no request.
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rsts_req", {31'b0, u_if.imem_req}, 32'd0);
        chk("rsts_valid", {31'b0, valid_IF}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            push(32'(i * 4));
            chk("stream_addr", u_if.imem_addr, 32'(i * 4));
            chk("stream_valid", {31'b0, valid_IF}, 32'd1);
        end

        // Redirect with ack drops the data; restart at 8 with a 2-cycle wait.
        cyc(1'b0, 1'b1, 32'h8, 1'b0, 1'b1);
        chk("rd_ack_valid", {31'b0, valid_IF}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("wait_addr", u_if.imem_addr, 32'h8);
            chk("wait_req", {31'b0, u_if.imem_req}, 32'd1);
            chk("wait_bubble", {31'b0, bubble_FD}, 32'd1);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h8);
        chk("wait_done", {31'b0, valid_IF}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'hC);

        // Stall in the ack cycle at 0x10, hold, then release.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        push(32'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            push(32'h10);
            chk("hold_req", {31'b0, u_if.imem_req}, 32'd0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h10);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h14);
        chk("after_hold_addr", u_if.imem_addr, 32'h14);

        // Enter HOLD at 0x18, then redirect to an unaligned target.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        push(32'h18);
        cyc(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
        chk("hold_rd_valid", {31'b0, valid_IF}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rd_addr", u_if.imem_addr, 32'h200);
        chk("rd_valid", {31'b0, valid_IF}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h200);

        // Wraparound from the top of the address space.
        cyc(1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
        chk("rd2_valid", {31'b0, valid_IF}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'hFFFFFFFC);
        chk("top_pc4", PCPlus4_IF, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap_addr", u_if.imem_addr, 32'h0);

        // Reset beats redirect while waiting; an ack in RST_S is ignored.
        cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst2_req", {31'b0, u_if.imem_req}, 32'd0);
        chk("rst2_valid", {31'b0, valid_IF}, 32'd0);
        chk("rst2_pc", PC_IF, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst2_addr", u_if.imem_addr, 32'h0);
        chk("rst2_req1", {31'b0, u_if.imem_req}, 32'd1);

        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
